sub_unit: RTL and testbench

Registered two's-complement subtractor for the Y86-64 ALU datapath. It computes `x - y` on signed 64-bit operands and flags signed overflow. The difference is built structurally as a ripple-carry adder of `x + ~y + 1`. Both results are captured in output registers on the rising clock edge, and downstream ALU and condition-code logic consume them one cycle after the operands are presented.

---
 rtl/sub_unit_pkg.sv | 6 +
 rtl/sub_unit_full_adder.sv | 13 +
 rtl/sub_unit.sv | 45 ++++
 tb/tb_sub_unit.sv | 93 +++++++++
 4 files changed

// File: rtl/sub_unit_pkg.sv
// sub_unit_pkg: shared ALU word constants for the Y86-64 datapath
package sub_unit_pkg;
    localparam int          WORD_W   = 64;
    localparam logic [63:0] WORD_MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] WORD_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
endpackage

// File: rtl/sub_unit_full_adder.sv
// full_adder: 1-bit gate-level full adder shared by the ALU add/sub blocks
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/sub_unit.sv
// sub_unit: registered two's-complement subtractor x - y with signed overflow flag
module sub_unit
    import sub_unit_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sub,
    output logic             of
);
    logic [WIDTH-1:0] yn;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   c;
    logic             c_unused;
    logic             of_c;
    assign yn       = ~y;
    assign c[0]     = 1'b1;
    assign c_unused = c[WIDTH];
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .a   (x[i]),
                .b   (yn[i]),
                .cin (c[i]),
                .s   (d[i]),
                .cout(c[i+1])
            );
        end
    endgenerate
    // Overflow only when operand signs differ and the result sign leaves the minuend's
    assign of_c = (x[WIDTH-1] ^ y[WIDTH-1]) & (d[WIDTH-1] ^ x[WIDTH-1]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub <= '0;
            of  <= 1'b0;
        end else begin
            sub <= d;
            of  <= of_c;
        end
    end
endmodule

// File: tb/tb_sub_unit.sv
// tb_sub_unit: scoreboard bench for sub_unit, directed edge cases plus random vectors
module tb_sub_unit;
    import sub_unit_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] x, y, sub;
    logic        of;
    int          total = 0;
    int          passes = 0;
    typedef struct {
        logic [63:0] s;
        logic        o;
        string       tag;
    } exp_t;
    exp_t q[$];

    sub_unit #(.WIDTH(64)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .x    (x),
        .y    (y),
        .sub  (sub),
        .of   (of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] es, input logic eo, input string tag);
        exp_t e;
        @(negedge clk);
        x = a;
        y = b;
        q.push_back('{es, eo, tag});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({e.tag, ".sub"}, sub, e.s);
        chk({e.tag, ".of"}, {63'd0, of}, {63'd0, e.o});
    endtask

    initial begin
        logic [63:0] a, b, m;
        logic        mo;
        rst_n = 1'b0;
        x = 64'd7;
        y = 64'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.sub", sub, 64'd0);
        chk("reset.of", {63'd0, of}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(64'd5, 64'd3, 64'd2, 1'b0, "pos");
        drive(64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "neg");
        drive(WORD_MIN, 64'd1, WORD_MAX, 1'b1, "min_m1");
        drive(WORD_MAX, '1, WORD_MIN, 1'b1, "max_p1");
        drive(64'd0, WORD_MIN, WORD_MIN, 1'b1, "zero_min");
        drive(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, "equal");
        drive(WORD_MIN, WORD_MIN, 64'd0, 1'b0, "min_min");
        drive('1, WORD_MIN, WORD_MAX, 1'b0, "m1_min");
        drive(64'd0, 64'd1, '1, 1'b0, "zero_one");
        drive(64'd10, 64'd4, 64'd6, 1'b0, "hold");
        // Drop reset between edges: outputs must clear with no clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async.sub", sub, 64'd0);
        chk("rst_async.of", {63'd0, of}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_hold.sub", sub, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_release.sub", sub, 64'd6);
        chk("rst_release.of", {63'd0, of}, 64'd0);
        for (int i = 0; i < 10000; i++) begin
            a  = {$random, $random};
            b  = {$random, $random};
            m  = a - b;
            mo = (a[63] != b[63]) && (m[63] != a[63]);
            drive(a, b, m, mo, "rand");
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
